// File: rtl/cond_flag_if.sv
// cond_flag_if: groups the handshake and bus signals of cond_flag_unit.
//   Result channel : res_valid/res_ready, result, carry_in, overflow_in
//   Query channel  : cond_valid/cond_ready, cond_code
//   Answer channel : take_valid/take_ready, take
//   Status         : flags {N,Z,C,V}
// The master modport is the ALU/branch side; the slave modport is the flag unit.
interface cond_flag_if #(
  parameter int WIDTH = 32
);
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry_in;
  logic             overflow_in;
  logic             cond_valid;
  logic             cond_ready;
  logic [3:0]       cond_code;
  logic             take_valid;
  logic             take_ready;
  logic             take;
  logic [3:0]       flags;

  modport master (
    output res_valid, result, carry_in, overflow_in,
    output cond_valid, cond_code, take_ready,
    input  res_ready, cond_ready, take_valid, take, flags
  );

  modport slave (
    input  res_valid, result, carry_in, overflow_in,
    input  cond_valid, cond_code, take_ready,
    output res_ready, cond_ready, take_valid, take, flags
  );
endinterface

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: consumer of ALU results. Derives N/Z/C/V from each accepted
// result, keeps them in an architectural flag register, and answers
// condition-code queries through a one-deep pipeline register with
// output backpressure.
//
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - cond_flag_if.slave (result, query and answer channels, flags)
//
// Optional build macro: FLAG_FORWARD_EN. When defined, a query transferring
// in the same cycle as a result is evaluated against the flags derived from
// that result instead of the registered flags.
//
// state | meaning
// IDLE  | no evaluation pending, take_valid low
// HOLD  | evaluation registered, take/take_valid held until take_ready
module cond_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  cond_flag_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       take_q, take_d;

  logic       res_fire;
  logic       cond_fire;
  logic       take_valid;
  logic [3:0] new_flags;
  logic [3:0] eval_flags;

  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = f;
    case (code)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = c;
      4'h3:    r = !c;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = c & !z;
      4'h9:    r = !c | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z & (n == v);
      4'hD:    r = z | (n != v);
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign take_valid = (state_q == HOLD);

  // Ready signals are forced low while reset is held, hence gated by reset_n.
  assign bus.res_ready  = reset_n;
  assign bus.cond_ready = reset_n & (!take_valid | bus.take_ready);

  assign res_fire  = bus.res_valid & bus.res_ready;
  assign cond_fire = bus.cond_valid & bus.cond_ready;

  assign new_flags = {bus.result[WIDTH-1], ~|bus.result, bus.carry_in, bus.overflow_in};

`ifdef FLAG_FORWARD_EN
  assign eval_flags = res_fire ? new_flags : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  always_comb begin
    state_d = state_q;
    take_d  = take_q;
    flags_d = flags_q;

    if (res_fire) begin
      flags_d = new_flags;
    end

    // A held answer is only replaced by a new query, which can only transfer
    // once the current answer is being consumed (cond_ready).
    if (cond_fire) begin
      take_d = eval_cond(bus.cond_code, eval_flags);
    end

    case (state_q)
      IDLE: begin
        if (cond_fire) state_d = HOLD;
      end
      HOLD: begin
        if (bus.take_ready && !cond_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      flags_q <= 4'b0000;
      take_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      take_q  <= take_d;
    end
  end

  assign bus.take_valid = take_valid;
  assign bus.take       = take_q;
  assign bus.flags      = flags_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  cond_flag_if #(.WIDTH(32)) bus ();

  cond_flag_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected take for flags N=1 Z=0 C=0 V=1, codes 0..F.
  logic [15:0] sweep_exp;
  logic        fwd_exp;

  initial begin
    n_checks = 0;
    n_errors = 0;
    sweep_exp = 16'b0101_0110_0101_1010; // bit i = expected take for code i
`ifdef FLAG_FORWARD_EN
    fwd_exp = 1'b1;
`else
    fwd_exp = 1'b0;
`endif

    // Reset with a result presented
    reset_n = 1'b0;
    bus.res_valid = 1'b1;
    bus.result = 32'h0;
    bus.carry_in = 1'b1;
    bus.overflow_in = 1'b1;
    bus.cond_valid = 1'b0;
    bus.cond_code = 4'h0;
    bus.take_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_flags", {28'h0, bus.flags}, 32'h0);
    check("rst_take_valid", {31'h0, bus.take_valid}, 32'h0);
    check("rst_take", {31'h0, bus.take}, 32'h0);
    check("rst_res_ready", {31'h0, bus.res_ready}, 32'h0);
    check("rst_cond_ready", {31'h0, bus.cond_ready}, 32'h0);

    bus.res_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    check("rel_res_ready", {31'h0, bus.res_ready}, 32'h1);
    check("rel_cond_ready", {31'h0, bus.cond_ready}, 32'h1);

    // Zero detect and flag derivation
    @(negedge clk);
    bus.res_valid = 1'b1; bus.result = 32'h0; bus.carry_in = 1'b1; bus.overflow_in = 1'b0;
    @(negedge clk);
    check("flags_zero", {28'h0, bus.flags}, 32'h6);
    bus.result = 32'h8000_0000; bus.carry_in = 1'b0; bus.overflow_in = 1'b1;
    @(negedge clk);
    check("flags_neg_ov", {28'h0, bus.flags}, 32'h9);
    bus.result = 32'h0000_0001; bus.carry_in = 1'b0; bus.overflow_in = 1'b0;
    @(negedge clk);
    check("flags_one_z", {31'h0, bus.flags[2]}, 32'h0);
    check("flags_one", {28'h0, bus.flags}, 32'h0);
    bus.result = 32'h8000_0000; bus.carry_in = 1'b0; bus.overflow_in = 1'b1;
    @(negedge clk);
    bus.res_valid = 1'b0;
    check("flags_1001", {28'h0, bus.flags}, 32'h9);

    // Back-to-back condition sweep
    bus.take_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.cond_valid = 1'b1;
      bus.cond_code = 4'(i);
      @(negedge clk);
      check($sformatf("sweep_valid_%0h", i), {31'h0, bus.take_valid}, 32'h1);
      check($sformatf("sweep_take_%0h", i), {31'h0, bus.take}, {31'h0, sweep_exp[i]});
    end
    bus.cond_valid = 1'b0;
    @(negedge clk);
    check("sweep_idle", {31'h0, bus.take_valid}, 32'h0);

    // Backpressure: EQ (false with flags 1001) held while NE waits
    bus.take_ready = 1'b0;
    bus.cond_valid = 1'b1;
    bus.cond_code = 4'h0;
    @(negedge clk);
    bus.cond_code = 4'h1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_valid_%0d", i), {31'h0, bus.take_valid}, 32'h1);
      check($sformatf("bp_take_%0d", i), {31'h0, bus.take}, 32'h0);
      check($sformatf("bp_cond_ready_%0d", i), {31'h0, bus.cond_ready}, 32'h0);
      @(negedge clk);
    end
    bus.take_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'h0, bus.cond_ready}, 32'h1);
    @(negedge clk);
    check("bp_ne_valid", {31'h0, bus.take_valid}, 32'h1);
    check("bp_ne_take", {31'h0, bus.take}, 32'h1);
    bus.cond_valid = 1'b0;
    @(negedge clk);
    check("bp_idle", {31'h0, bus.take_valid}, 32'h0);

    // Same-cycle result and query
    bus.res_valid = 1'b1; bus.result = 32'h0000_0001; bus.carry_in = 1'b0; bus.overflow_in = 1'b0;
    @(negedge clk);
    check("same_pre_flags", {28'h0, bus.flags}, 32'h0);
    bus.result = 32'h0;
    bus.cond_valid = 1'b1;
    bus.cond_code = 4'h0;
    bus.take_ready = 1'b0;
    @(negedge clk);
    bus.res_valid = 1'b0;
    bus.cond_valid = 1'b0;
    check("same_take", {31'h0, bus.take}, {31'h0, fwd_exp});
    check("same_flags", {28'h0, bus.flags}, 32'h4);

    // Result during HOLD updates flags but not the held answer
    bus.res_valid = 1'b1; bus.result = 32'h0000_0001; bus.carry_in = 1'b1; bus.overflow_in = 1'b1;
    @(negedge clk);
    bus.res_valid = 1'b0;
    check("hold_flags", {28'h0, bus.flags}, 32'h3);
    check("hold_take", {31'h0, bus.take}, {31'h0, fwd_exp});
    check("hold_valid", {31'h0, bus.take_valid}, 32'h1);

    // Reset mid-HOLD
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", {31'h0, bus.take_valid}, 32'h0);
    check("midrst_flags", {28'h0, bus.flags}, 32'h0);
    check("midrst_cond_ready", {31'h0, bus.cond_ready}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'h0, bus.take_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
